// File: rtl/prog_mem_pkg.sv
// Shared constants and FSM state encoding for the program memory controller.
package prog_mem_pkg;

    // Default instruction width and address width.
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

    // Controller state: waiting for first load, loading, program ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/program_mem_ctrl_if.sv
// Bus bundle between the boot loader / processor side (master) and the controller (slave).
//
// Load handshake: a word moves on a rising edge exactly when ld_valid and
// ld_ready are both 1. ld_valid without ld_ready does nothing, and the
// master may change ld_data freely while no transfer happens. ld_ready
// depends only on controller state, never on ld_valid.
interface program_mem_ctrl_if #(
    parameter int DATA_W = prog_mem_pkg::DATA_W_DEF,
    parameter int ADDR_W = prog_mem_pkg::ADDR_W_DEF
) ();

    // Boot load stream
    logic              load_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;

    // Load status
    logic              load_busy;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   prog_len;
    logic              cpu_hold;

    // Instruction fetch
    logic              rden;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              rd_oob;

    modport master (
        output load_start, ld_valid, ld_data, ld_last, rden, rd_addr,
        input  ld_ready, load_busy, load_done, load_err, prog_len, cpu_hold,
               instr, instr_valid, rd_oob
    );

    modport slave (
        input  load_start, ld_valid, ld_data, ld_last, rden, rd_addr,
        output ld_ready, load_busy, load_done, load_err, prog_len, cpu_hold,
               instr, instr_valid, rd_oob
    );

endinterface

// File: rtl/prog_mem_ram.sv
// Program storage: one write port, one synchronous read port, contents not reset.
module prog_mem_ram #(
    parameter int DATA_W = prog_mem_pkg::DATA_W_DEF,
    parameter int ADDR_W = prog_mem_pkg::ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port: store the accepted load word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: registered read, holds the last value when not enabled.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/program_mem_ctrl.sv
// Boot-loads a program image into on-chip memory, then serves instruction
// fetches while releasing the processor from reset.
module program_mem_ctrl #(
    parameter int DATA_W = prog_mem_pkg::DATA_W_DEF,
    parameter int ADDR_W = prog_mem_pkg::ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    program_mem_ctrl_if.slave     bus_if,
    output prog_mem_pkg::state_t  dbg_state_o
);

    import prog_mem_pkg::*;

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic              instr_valid_q, instr_valid_d;
    logic              rd_oob_q, rd_oob_d;

    logic              ld_ready;
    logic              load_busy;
    logic              cpu_hold;
    logic              start_acc;
    logic              xfer;
    logic              at_last;
    logic              fetch;
    logic [DATA_W-1:0] ram_rdata;

    // A start request only counts outside LOAD; a running load cannot be restarted.
    assign start_acc = bus_if.load_start && (state_q != LOAD);
    assign xfer      = bus_if.ld_valid && ld_ready;
    assign at_last   = (wr_ptr_q == LAST_ADDR);
    // Fetches are gated by cpu_hold, so they can never collide with a load write.
    assign fetch     = bus_if.rden && !cpu_hold;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start from IDLE/DONE, finish on the last word or a full memory.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus_if.load_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (xfer && (bus_if.ld_last || at_last)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs: ready/busy while loading, processor released only in DONE.
    always_comb begin
        ld_ready  = 1'b0;
        load_busy = 1'b0;
        cpu_hold  = 1'b1;
        case (state_q)
            LOAD: begin
                ld_ready  = 1'b1;
                load_busy = 1'b1;
            end
            DONE: begin
                cpu_hold = 1'b0;
            end
            default: ;
        endcase
    end

    // Load bookkeeping: clear on start, advance on each transfer; pointer saturates at the top.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        prog_len_d  = prog_len_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        if (start_acc) begin
            wr_ptr_d    = '0;
            prog_len_d  = '0;
            load_done_d = 1'b0;
            load_err_d  = 1'b0;
        end else if (xfer) begin
            prog_len_d = prog_len_q + 1'b1;
            if (!at_last) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (bus_if.ld_last) begin
                load_done_d = 1'b1;
                load_err_d  = 1'b0;
            end else if (at_last) begin
                load_done_d = 1'b1;
                load_err_d  = 1'b1;
            end
        end
    end

    // Load bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            prog_len_q  <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            prog_len_q  <= prog_len_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    // Fetch qualifiers for the cycle after the request.
    always_comb begin
        instr_valid_d = fetch;
        rd_oob_d      = fetch && ({1'b0, bus_if.rd_addr} >= prog_len_q);
    end

    // Fetch qualifier registers; they also mask the unreset RAM output after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid_q <= 1'b0;
            rd_oob_q      <= 1'b0;
        end else begin
            instr_valid_q <= instr_valid_d;
            rd_oob_q      <= rd_oob_d;
        end
    end

    prog_mem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (xfer),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus_if.ld_data),
        .re_i    (fetch),
        .raddr_i (bus_if.rd_addr),
        .rdata_o (ram_rdata)
    );

    assign bus_if.ld_ready    = ld_ready;
    assign bus_if.load_busy   = load_busy;
    assign bus_if.cpu_hold    = cpu_hold;
    assign bus_if.load_done   = load_done_q;
    assign bus_if.load_err    = load_err_q;
    assign bus_if.prog_len    = prog_len_q;
    assign bus_if.instr_valid = instr_valid_q;
    assign bus_if.rd_oob      = rd_oob_q;
    assign bus_if.instr       = (instr_valid_q && !rd_oob_q) ? ram_rdata : '0;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_program_mem_ctrl.sv
// Self-checking bench for program_mem_ctrl.
module tb_program_mem_ctrl;

    import prog_mem_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int W      = DATA_W + 2;

    // ---------------- clock / reset ----------------
    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    always #5 clk = ~clk;

    program_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    program_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_if      (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- model / scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] model_mem [DEPTH];
    int   model_len  = 0;
    logic model_done = 1'b0;
    logic [W-1:0] exp_q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.load_start = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        bus.ld_last    = 1'b0;
        bus.rden       = 1'b0;
        bus.rd_addr    = '0;
    endtask

    // Called at a negedge; leaves the controller in LOAD at the next negedge.
    task automatic start_load();
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        model_len  = 0;
        model_done = 1'b0;
    endtask

    // Called at a negedge while LOAD is expected; returns at the negedge after the transfer.
    task automatic send_word(input logic [DATA_W-1:0] data, input logic last);
        checks++;
        if (bus.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL ld_ready_before_word: got %0b, required 1", bus.ld_ready);
        end
        bus.ld_valid = 1'b1;
        bus.ld_data  = data;
        bus.ld_last  = last;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        bus.ld_data  = DATA_W'($urandom_range(0, 16'hFFFF));
        model_mem[model_len] = data;
        model_len++;
        if (last || model_len == DEPTH) model_done = 1'b1;
    endtask

    // One fetch: push expected {instr, instr_valid, rd_oob}, compare one cycle later.
    task automatic fetch(input int addr);
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;
        bus.rden    = 1'b1;
        bus.rd_addr = ADDR_W'(addr);
        if (!model_done)           exp_v = {{DATA_W{1'b0}}, 1'b0, 1'b0};
        else if (addr >= model_len) exp_v = {{DATA_W{1'b0}}, 1'b1, 1'b1};
        else                       exp_v = {model_mem[addr], 1'b1, 1'b0};
        exp_q.push_back(exp_v);
        @(negedge clk);
        bus.rden = 1'b0;
        got_v = {bus.instr, bus.instr_valid, bus.rd_oob};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL fetch_addr_%0d: got instr=%h valid=%0b oob=%0b, required instr=%h valid=%0b oob=%0b",
                     addr, got_v[W-1:2], got_v[1], got_v[0], exp_v[W-1:2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic check_status(input string name, input logic busy, input logic done,
                                input logic err, input int len, input logic hold);
        checks++;
        if (bus.load_busy !== busy || bus.ld_ready !== busy || bus.load_done !== done ||
            bus.load_err !== err || bus.prog_len !== (ADDR_W+1)'(len) || bus.cpu_hold !== hold) begin
            errors++;
            $display("FAIL %s: got busy=%0b rdy=%0b done=%0b err=%0b len=%0d hold=%0b, required busy=%0b rdy=%0b done=%0b err=%0b len=%0d hold=%0b",
                     name, bus.load_busy, bus.ld_ready, bus.load_done, bus.load_err, bus.prog_len,
                     bus.cpu_hold, busy, busy, done, err, len, hold);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_status("reset_status", 1'b0, 1'b0, 1'b0, 0, 1'b1);
        checks++;
        if (bus.instr !== '0 || bus.instr_valid !== 1'b0 || bus.rd_oob !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_fetch_outputs: got instr=%h valid=%0b oob=%0b state=%0d, required 0/0/0/IDLE",
                     bus.instr, bus.instr_valid, bus.rd_oob, dbg_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
        fetch(0);  // held in IDLE: no valid fetch
    endtask

    task automatic test_basic_load();
        start_load();
        check_status("load_entered", 1'b1, 1'b0, 1'b0, 0, 1'b1);
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        send_word(16'h3333, 1'b1);
        check_status("basic_done", 1'b0, 1'b1, 1'b0, 3, 1'b0);
        checks++;
        if (dbg_state !== DONE) begin
            errors++;
            $display("FAIL basic_state: got %0d, required %0d", dbg_state, DONE);
        end
        fetch(1);
        fetch(0);
        fetch(2);
    endtask

    task automatic test_gaps();
        logic [DATA_W-1:0] w;
        start_load();
        for (int i = 0; i < 4; i++) begin
            w = DATA_W'($urandom_range(0, 16'hFFFF));
            send_word(w, i == 3);
            if (i != 3) begin
                for (int g = 0; g < i + 1; g++) begin
                    bus.ld_data = DATA_W'($urandom_range(0, 16'hFFFF));
                    @(negedge clk);
                end
            end
        end
        check_status("gaps_done", 1'b0, 1'b1, 1'b0, 4, 1'b0);
        // valid without ready in DONE must not write or count
        bus.ld_valid = 1'b1;
        bus.ld_last  = 1'b1;
        bus.ld_data  = 16'hDEAD;
        repeat (2) @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check_status("valid_without_ready", 1'b0, 1'b1, 1'b0, 4, 1'b0);
        for (int a = 0; a < 4; a++) fetch(a);
    endtask

    task automatic test_oob();
        start_load();
        send_word(16'hA001, 1'b0);
        send_word(16'hA002, 1'b0);
        send_word(16'hA003, 1'b1);
        fetch(5);
        fetch(3);
        fetch(2);
        // rden low: outputs return to zero after one edge
        @(negedge clk);
        checks++;
        if (bus.instr !== '0 || bus.instr_valid !== 1'b0 || bus.rd_oob !== 1'b0) begin
            errors++;
            $display("FAIL rden_low: got instr=%h valid=%0b oob=%0b, required 0/0/0",
                     bus.instr, bus.instr_valid, bus.rd_oob);
        end
    endtask

    task automatic test_overflow();
        start_load();
        for (int i = 0; i < DEPTH; i++) begin
            send_word(DATA_W'(i * 7 + 16'h0100), 1'b0);
        end
        check_status("overflow_done", 1'b0, 1'b1, 1'b1, 256, 1'b0);
        // 257th word is offered but cannot be accepted
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'hBEEF;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        check_status("overflow_257th", 1'b0, 1'b1, 1'b1, 256, 1'b0);
        fetch(0);
        fetch(255);
        fetch(128);
    endtask

    task automatic test_reset_mid_load();
        start_load();
        send_word(16'h5555, 1'b0);
        send_word(16'h6666, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_status("async_reset_mid_load", 1'b0, 1'b0, 1'b0, 0, 1'b1);
        checks++;
        if (bus.instr !== '0 || bus.instr_valid !== 1'b0 || bus.rd_oob !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL async_reset_fetch: got instr=%h valid=%0b oob=%0b state=%0d, required 0/0/0/IDLE",
                     bus.instr, bus.instr_valid, bus.rd_oob, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_done = 1'b0;
        model_len  = 0;
        @(negedge clk);
        fetch(0);
        fetch(1);
        check_status("after_reset_idle", 1'b0, 1'b0, 1'b0, 0, 1'b1);
        start_load();
        send_word(16'hAAAA, 1'b0);
        send_word(16'hBBBB, 1'b1);
        check_status("reload_after_reset", 1'b0, 1'b1, 1'b0, 2, 1'b0);
        fetch(0);
        fetch(1);
        fetch(2);
    endtask

    task automatic test_start_during_load();
        start_load();
        send_word(16'h7001, 1'b0);
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        check_status("start_ignored_in_load", 1'b1, 1'b0, 1'b0, 1, 1'b1);
        send_word(16'h7002, 1'b0);
        send_word(16'h7003, 1'b1);
        check_status("load_continued", 1'b0, 1'b1, 1'b0, 3, 1'b0);
        start_load();
        check_status("reload_clears", 1'b1, 1'b0, 1'b0, 0, 1'b1);
        send_word(16'h8001, 1'b1);
        check_status("reload_done", 1'b0, 1'b1, 1'b0, 1, 1'b0);
        fetch(0);
        fetch(1);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        idle_inputs();
        test_reset();
        test_basic_load();
        test_gaps();
        test_oob();
        test_overflow();
        test_reset_mid_load();
        test_start_during_load();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
